// File: rtl/btn_pkg.sv
// Shared helpers for the button conditioner: counter sizing and the
// raw pin value that means "released" for a given polarity.
package btn_pkg;

  // Width of a counter that must hold values 0 .. n-1 (at least one bit).
  function automatic int cnt_w(input int n);
    int w;
    w = $clog2(n);
    if (w < 1) begin
      return 1;
    end else begin
      return w;
    end
  endfunction

  // Raw pin level seen when the button is not pressed.
  function automatic logic raw_released(input int active_low);
    if (active_low != 0) begin
      return 1'b1;
    end else begin
      return 1'b0;
    end
  endfunction

endpackage

// File: rtl/btn_channel.sv
// One button channel: synchroniser chain, polarity normalisation,
// stable-count debounce, press/release strobes and optional long-press strobe.
module btn_channel
  import btn_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int ACTIVE_LOW      = 1,
  parameter int LONG_CYCLES     = 0
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_in,
  output logic level,
  output logic press,
  output logic rel_pulse,
  output logic hold_pulse
);

  localparam int                     CW        = cnt_w(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0]          CNT_MAX   = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0]          CNT_ONE   = CW'(1);
  localparam logic                   RAW_REL   = raw_released(ACTIVE_LOW);
  localparam logic [SYNC_STAGES-1:0] SYNC_INIT = {SYNC_STAGES{RAW_REL}};

  logic [SYNC_STAGES-1:0] sync_r;
  logic                   pressed_s;
  logic [CW-1:0]          cnt_r;
  logic [CW-1:0]          cnt_next_s;
  logic                   level_r;
  logic                   level_next_s;
  logic                   press_r;
  logic                   press_next_s;
  logic                   rel_r;
  logic                   rel_next_s;

  // Synchroniser chain; reset loads the released pin value so no false edge appears.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_r <= SYNC_INIT;
    end else begin
      sync_r <= {sync_r[SYNC_STAGES-2:0], btn_in};
    end
  end

  // XOR with the released level maps "released" to 0 for either polarity.
  assign pressed_s = sync_r[SYNC_STAGES-1] ^ RAW_REL;

  // Debounce: accept a new level only after DEBOUNCE_CYCLES consecutive differing samples.
  always_comb begin
    cnt_next_s   = {CW{1'b0}};
    level_next_s = level_r;
    press_next_s = 1'b0;
    rel_next_s   = 1'b0;
    if (pressed_s == level_r) begin
      cnt_next_s = {CW{1'b0}};
    end else if (cnt_r != CNT_MAX) begin
      cnt_next_s = cnt_r + CNT_ONE;
    end else begin
      cnt_next_s   = {CW{1'b0}};
      level_next_s = pressed_s;
      press_next_s = pressed_s;
      rel_next_s   = ~pressed_s;
    end
  end

  // Debounce state and strobe registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_r   <= {CW{1'b0}};
      level_r <= 1'b0;
      press_r <= 1'b0;
      rel_r   <= 1'b0;
    end else begin
      cnt_r   <= cnt_next_s;
      level_r <= level_next_s;
      press_r <= press_next_s;
      rel_r   <= rel_next_s;
    end
  end

  assign level     = level_r;
  assign press     = press_r;
  assign rel_pulse = rel_r;

  if (LONG_CYCLES > 0) begin : g_long
    localparam int            HW       = cnt_w(LONG_CYCLES + 1);
    localparam logic [HW-1:0] HOLD_MAX = HW'(LONG_CYCLES);
    localparam logic [HW-1:0] HOLD_PRE = HW'(LONG_CYCLES - 1);
    localparam logic [HW-1:0] HOLD_ONE = HW'(1);

    logic [HW-1:0] hcnt_r;
    logic [HW-1:0] hcnt_next_s;
    logic          hold_r;
    logic          hold_next_s;

    // Hold counter follows the level being registered this edge, so the press
    // cycle itself counts as the first held cycle; it saturates for one pulse per press.
    always_comb begin
      hcnt_next_s = hcnt_r;
      hold_next_s = 1'b0;
      if (!level_next_s) begin
        hcnt_next_s = {HW{1'b0}};
      end else if (hcnt_r != HOLD_MAX) begin
        hcnt_next_s = hcnt_r + HOLD_ONE;
        hold_next_s = (hcnt_r == HOLD_PRE);
      end else begin
        hcnt_next_s = hcnt_r;
      end
    end

    // Long-press counter and strobe registers.
    always_ff @(posedge clk) begin
      if (reset) begin
        hcnt_r <= {HW{1'b0}};
        hold_r <= 1'b0;
      end else begin
        hcnt_r <= hcnt_next_s;
        hold_r <= hold_next_s;
      end
    end

    assign hold_pulse = hold_r;
  end else begin : g_no_long
    assign hold_pulse = 1'b0;
  end

endmodule

// File: rtl/button_conditioner.sv
// N-channel conditioner for asynchronous buttons/switches: one independent
// btn_channel per input, no logic shared between channels.
module button_conditioner
  import btn_pkg::*;
#(
  parameter int N_CH            = 2,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int ACTIVE_LOW      = 1,
  parameter int LONG_CYCLES     = 0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [N_CH-1:0] btn_in,
  output logic [N_CH-1:0] level,
  output logic [N_CH-1:0] press,
  output logic [N_CH-1:0] rel_pulse,
  output logic [N_CH-1:0] hold_pulse
);

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    btn_channel #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .ACTIVE_LOW     (ACTIVE_LOW),
      .LONG_CYCLES    (LONG_CYCLES)
    ) u_ch (
      .clk       (clk),
      .reset     (reset),
      .btn_in    (btn_in[i]),
      .level     (level[i]),
      .press     (press[i]),
      .rel_pulse (rel_pulse[i]),
      .hold_pulse(hold_pulse[i])
    );
  end

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner (2 channels, 2 sync stages,
// debounce 4, active-low pins, long press 8).
module tb_button_conditioner;

  logic       clk;
  logic       reset;
  logic [1:0] btn_in;
  logic [1:0] level;
  logic [1:0] press;
  logic [1:0] rel_pulse;
  logic [1:0] hold_pulse;

  int err_cnt;
  int chk_cnt;

  button_conditioner #(
    .N_CH           (2),
    .SYNC_STAGES    (2),
    .DEBOUNCE_CYCLES(4),
    .ACTIVE_LOW     (1),
    .LONG_CYCLES    (8)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .btn_in    (btn_in),
    .level     (level),
    .press     (press),
    .rel_pulse (rel_pulse),
    .hold_pulse(hold_pulse)
  );

  // Free-running 10 ns clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one active edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int n);
    reset  = 1'b1;
    btn_in = 2'b11;
    for (int i = 0; i < n; i++) step();
    reset = 1'b0;
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_press"}, {30'd0, press}, 32'd0);
    check({tag, "_rel"},   {30'd0, rel_pulse}, 32'd0);
    check({tag, "_hold"},  {30'd0, hold_pulse}, 32'd0);
  endtask

  initial begin
    int hold_seen;
    err_cnt = 0;
    chk_cnt = 0;

    // 1: reset for 3 cycles with both buttons released.
    reset  = 1'b1;
    btn_in = 2'b11;
    for (int i = 0; i < 3; i++) step();
    check("rst_level", {30'd0, level}, 32'd0);
    check_quiet("rst");
    reset = 1'b0;

    // 2: ch0 pressed before edge 1 -> level/press at edge 6 only.
    btn_in = 2'b10;
    for (int e = 1; e <= 6; e++) begin
      step();
      check($sformatf("lat_level_e%0d", e), {30'd0, level}, (e == 6) ? 32'd1 : 32'd0);
      check($sformatf("lat_press_e%0d", e), {30'd0, press}, (e == 6) ? 32'd1 : 32'd0);
    end
    step();
    check("lat_press_clr", {30'd0, press}, 32'd0);
    check("lat_level_hold", {30'd0, level}, 32'd1);

    // 3: ch0 low for only 3 cycles -> no change at all.
    do_reset(2);
    btn_in = 2'b10;
    for (int e = 1; e <= 3; e++) step();
    btn_in = 2'b11;
    for (int e = 4; e <= 10; e++) begin
      step();
      check($sformatf("bounce_level_e%0d", e), {30'd0, level}, 32'd0);
      check($sformatf("bounce_press_e%0d", e), {30'd0, press}, 32'd0);
    end

    // 4: ch1 pressed, then ch0 press and ch1 release land on the same edge.
    do_reset(2);
    btn_in = 2'b01;
    for (int e = 1; e <= 6; e++) step();
    check("sim_p1_level", {30'd0, level}, 32'd2);
    check("sim_p1_press", {30'd0, press}, 32'd2);
    step();
    btn_in = 2'b10;
    for (int e = 1; e <= 5; e++) step();
    check("sim_pre_level", {30'd0, level}, 32'd2);
    step();
    check("sim_level", {30'd0, level}, 32'd1);
    check("sim_press", {30'd0, press}, 32'd1);
    check("sim_rel", {30'd0, rel_pulse}, 32'd2);
    check("sim_nohold", {30'd0, hold_pulse}, 32'd0);

    // 5: reset mid-count (cnt=2) discards progress.
    do_reset(2);
    btn_in = 2'b10;
    for (int e = 1; e <= 4; e++) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("midrst_level", {30'd0, level}, 32'd0);
    check_quiet("midrst");
    for (int e = 1; e <= 6; e++) begin
      step();
      check($sformatf("midrst_press_e%0d", e), {30'd0, press}, (e == 6) ? 32'd1 : 32'd0);
    end
    check("midrst_level_e6", {30'd0, level}, 32'd1);

    // 6: long press -> one hold pulse 7 cycles after press, none after release.
    do_reset(2);
    btn_in = 2'b10;
    for (int e = 1; e <= 6; e++) step();
    check("long_press", {30'd0, press}, 32'd1);
    hold_seen = 0;
    for (int k = 1; k <= 20; k++) begin
      step();
      check($sformatf("long_hold_k%0d", k), {30'd0, hold_pulse}, (k == 7) ? 32'd1 : 32'd0);
      if (hold_pulse[0]) hold_seen++;
    end
    check("long_hold_once", hold_seen, 32'd1);
    btn_in = 2'b11;
    for (int e = 1; e <= 6; e++) begin
      step();
      check($sformatf("long_rel_e%0d", e), {30'd0, rel_pulse}, (e == 6) ? 32'd1 : 32'd0);
      check($sformatf("long_relhold_e%0d", e), {30'd0, hold_pulse}, 32'd0);
    end
    check("long_level_off", {30'd0, level}, 32'd0);
    for (int e = 0; e < 10; e++) step();
    check_quiet("long_idle");

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
